// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction in, datapath control bundle out
interface control_sequencer_if;
  logic [31:0] instruction;
  logic        branch;
  logic        is_lui;
  logic        is_jal;
  logic        is_jalr;
  logic        mem2reg;
  logic        memwrite;
  logic        alusrc;
  logic        regwrite;
  logic [3:0]  aluctl;
  logic        pc_stall;

  modport master (
    input  instruction,
    output branch, is_lui, is_jal, is_jalr, mem2reg, memwrite,
    output alusrc, regwrite, aluctl, pc_stall
  );

  modport slave (
    output instruction,
    input  branch, is_lui, is_jal, is_jalr, mem2reg, memwrite,
    input  alusrc, regwrite, aluctl, pc_stall
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle RV32 control FSM with load writeback, trap and counters
module control_sequencer #(
  parameter int CNT_W = 32,
  parameter int WDOG  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  control_sequencer_if.master  ctrl,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOAD_WB, S_HALT} state_e;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       branch_c, is_lui_c, is_jal_c, is_jalr_c;
  logic       mem2reg_c, memwrite_c, alusrc_c, regwrite_c, pc_stall_c;
  logic [3:0] aluctl_c;
  logic       retire;
  logic       wdog_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_bits;

  assign opcode      = ctrl.instruction[6:0];
  assign funct3      = ctrl.instruction[14:12];
  assign f7b5        = ctrl.instruction[30];
  assign unused_bits = ^{ctrl.instruction[31], ctrl.instruction[29:15], ctrl.instruction[11:7]};

  // sub_en selects SUB for funct3=000 (R-type only); sra_en selects SRA for funct3=101
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic sub_en, input logic sra_en);
    case (f3)
      3'b000:  alu_op = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  assign wdog_hit = (WDOG != 0) && (cycle_q == CNT_W'(WDOG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    branch_c   = 1'b0;
    is_lui_c   = 1'b0;
    is_jal_c   = 1'b0;
    is_jalr_c  = 1'b0;
    mem2reg_c  = 1'b0;
    memwrite_c = 1'b0;
    alusrc_c   = 1'b0;
    regwrite_c = 1'b0;
    aluctl_c   = ALU_ADD;
    pc_stall_c = 1'b1;
    retire     = 1'b0;
    state_d    = state_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    cycle_d    = cycle_q;
    instret_d  = instret_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        pc_stall_c = 1'b0;
        retire     = 1'b1;
        case (opcode)
          7'b0110011: begin
            regwrite_c = 1'b1;
            aluctl_c   = alu_op(funct3, f7b5, f7b5);
          end
          7'b0010011: begin
            regwrite_c = 1'b1;
            alusrc_c   = 1'b1;
            aluctl_c   = alu_op(funct3, 1'b0, f7b5);
          end
          7'b1101111: begin
            is_jal_c   = 1'b1;
            regwrite_c = 1'b1;
          end
          7'b1100111: begin
            is_jalr_c  = 1'b1;
            regwrite_c = 1'b1;
            alusrc_c   = 1'b1;
          end
          7'b0110111: begin
            is_lui_c   = 1'b1;
            regwrite_c = 1'b1;
          end
          7'b0000011, 7'b0100011, 7'b1100011: begin
            if (funct3 == 3'b010 && opcode == 7'b0000011) begin
              // Load data arrives a cycle late; retire happens in LOAD_WB
              alusrc_c   = 1'b1;
              mem2reg_c  = 1'b1;
              pc_stall_c = 1'b1;
              retire     = 1'b0;
              state_d    = S_LOAD_WB;
            end else if (funct3 == 3'b010 && opcode == 7'b0100011) begin
              alusrc_c   = 1'b1;
              memwrite_c = 1'b1;
            end else if (funct3 == 3'b000 && opcode == 7'b1100011) begin
              branch_c = 1'b1;
              aluctl_c = ALU_SUB;
            end else begin
              pc_stall_c = 1'b1;
              retire     = 1'b0;
              illegal_d  = 1'b1;
              state_d    = S_HALT;
            end
          end
          7'b1110011: begin
            pc_stall_c = 1'b1;
            retire     = 1'b0;
            state_d    = S_HALT;
          end
          default: begin
            pc_stall_c = 1'b1;
            retire     = 1'b0;
            illegal_d  = 1'b1;
            state_d    = S_HALT;
          end
        endcase
      end
      S_LOAD_WB: begin
        alusrc_c   = 1'b1;
        mem2reg_c  = 1'b1;
        regwrite_c = 1'b1;
        pc_stall_c = 1'b0;
        retire     = 1'b1;
        state_d    = S_RUN;
      end
      default: ;
    endcase

    if (state_q == S_RUN || state_q == S_LOAD_WB) begin
      cycle_d = cycle_q + CNT_W'(1);
      if (retire) instret_d = instret_q + CNT_W'(1);
      // Controls above are left intact so the in-flight write still lands
      if (wdog_hit) begin
        timeout_d = 1'b1;
        state_d   = S_HALT;
      end
    end
  end

  assign ctrl.branch   = branch_c;
  assign ctrl.is_lui   = is_lui_c;
  assign ctrl.is_jal   = is_jal_c;
  assign ctrl.is_jalr  = is_jalr_c;
  assign ctrl.mem2reg  = mem2reg_c;
  assign ctrl.memwrite = memwrite_c;
  assign ctrl.alusrc   = alusrc_c;
  assign ctrl.regwrite = regwrite_c;
  assign ctrl.aluctl   = aluctl_c;
  assign ctrl.pc_stall = pc_stall_c;

  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
